// File: rtl/save_writeback_if.sv
// Upstream word stream plus BRAM write port of the save write-back stage.
// Latency: none, wires only. Backpressure: mem_grant gates the BRAM writes.
interface save_writeback_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  save_wen;
    logic [DATA_WIDTH-1:0] bram_savedata;
    logic                  mem_grant;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  save_wen, bram_savedata, mem_grant,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output save_wen, bram_savedata, mem_grant,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/save_writeback.sv
// Generic FIFO with flush; accepts a push while full when a pop happens in the same cycle.
// Latency: 1 cycle push to out_vld. Backpressure: in_rdy low only when full and not popping.
module sw_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      cnt;
    logic             push, pop;

    assign out_vld = (cnt != '0);
    assign in_rdy  = (cnt != (AW+1)'(DEPTH)) || out_rdy;
    assign push    = in_vld && in_rdy && !flush;
    assign pop     = out_vld && out_rdy && !flush;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end
endmodule

// Save write-back: masks each lane to LOG_Q bits, buffers words, writes them sequentially to BRAM.
// Latency: 2 cycles save_wen to wr_en with empty FIFO and grant. Backpressure: none upstream, drops set overflow.
// Optional SAVE_WB_CHECKSUM_EN adds a per-job XOR checksum of issued write data.
module save_writeback #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LOG_Q      = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR_SAVE,
    input  logic [15:0]           WORD_COUNT,
    save_writeback_if.master      wb,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef SAVE_WB_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam int          LANES     = DATA_WIDTH / 16;
    localparam logic [15:0] LANE_MASK = 16'((32'd1 << LOG_Q) - 32'd1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           count_q, accepted, written;
    logic [DATA_WIDTH-1:0] masked, fifo_dat;
    logic                  fifo_in_rdy, fifo_out_vld;
    logic                  go, run_wen, push_req, push, pop, drop;

    always_comb begin
        masked = '0;
        for (int i = 0; i < LANES; i++)
            masked[16*i +: 16] = wb.bram_savedata[16*i +: 16] & LANE_MASK;
    end

    assign go       = (state_q == IDLE) && start;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign run_wen  = wb.save_wen && (state_q == RUN);
    assign push_req = run_wen && (accepted < count_q);
    assign push     = push_req && fifo_in_rdy;
    assign pop      = busy && fifo_out_vld && wb.mem_grant;
    // Surplus words in RUN and any word during DRAIN count as drops too.
    assign drop     = (push_req && !fifo_in_rdy) || (run_wen && (accepted >= count_q))
                    || (wb.save_wen && (state_q == DRAIN));

    sw_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (go),
        .in_vld  (push_req),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (masked),
        .out_vld (fifo_out_vld),
        .out_rdy (busy && wb.mem_grant),
        .out_dat (fifo_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (WORD_COUNT == 16'd0) ? DONE : RUN;
            RUN:     if (accepted == count_q) state_d = DRAIN;
            DRAIN:   if (!fifo_out_vld) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            count_q    <= '0;
            accepted   <= '0;
            written    <= '0;
            overflow   <= 1'b0;
            wb.wr_en   <= 1'b0;
            wb.wr_addr <= '0;
            wb.wr_data <= '0;
`ifdef SAVE_WB_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            wb.wr_en <= pop;
            if (pop) begin
                wb.wr_addr <= base_q + (ADDR_WIDTH'(written) << 3);
                wb.wr_data <= fifo_dat;
                written    <= written + 16'd1;
`ifdef SAVE_WB_CHECKSUM_EN
                checksum   <= checksum ^ fifo_dat;
`endif
            end
            if (go) begin
                base_q   <= BASE_ADDR_SAVE;
                count_q  <= WORD_COUNT;
                accepted <= '0;
                written  <= '0;
                overflow <= 1'b0;
`ifdef SAVE_WB_CHECKSUM_EN
                checksum <= '0;
`endif
            end else begin
                if (push) accepted <= accepted + 16'd1;
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule
